// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants, pixel colour width, and the
// per-position sync/display-enable decode used by the scan controller.
package vga_pkg;

  localparam int RGB_W = 12;   // 4:4:4 colour
  localparam int CNT_W = 10;   // wide enough for 0..799 and 0..524

  // Horizontal timing in pixels.
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800

  // Vertical timing in lines.
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525

  // Sync windows, start inclusive / end exclusive.
  localparam int H_SYNC_START = H_ACTIVE + H_FP;               // 656
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;         // 752
  localparam int V_SYNC_START = V_ACTIVE + V_FP;               // 490
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;         // 492

  typedef logic [CNT_W-1:0] cnt_t;

  // Video control bits. The syncs are active-low.
  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic de;
  } vid_ctl_t;

  localparam vid_ctl_t CTL_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, de: 1'b0};

  function automatic vid_ctl_t decode_pos(input cnt_t h, input cnt_t v);
    vid_ctl_t c;
    c.de      = (h < cnt_t'(H_ACTIVE)) && (v < cnt_t'(V_ACTIVE));
    c.hsync_n = !((h >= cnt_t'(H_SYNC_START)) && (h < cnt_t'(H_SYNC_END)));
    c.vsync_n = !((v >= cnt_t'(V_SYNC_START)) && (v < cnt_t'(V_SYNC_END)));
    return c;
  endfunction

endpackage

// File: rtl/vga_pix_ce.sv
// vga_pix_ce: pixel-enable divider.
//   clock  : system clock
//   res    : synchronous active-high reset
//   en     : run enable; low clears the divider
//   pix_ce : registered one-clock pulse, high while the divider sits at CLK_DIV-1
// The first enabled clock is spent with the divider parked at 0. As a result,
// the first pulse lands CLK_DIV clocks after en rises. CLK_DIV must be at least 2.
module vga_pix_ce #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic res,
  input  logic en,
  output logic pix_ce
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             run_q, run_d;
  logic             pix_ce_q, pix_ce_d;

  always_comb begin
    run_d = en;
    div_d = '0;
    if (en && run_q)
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    // The pulse is registered from the next divider value. This keeps pix_ce
    // aligned with the divider holding DIV_LAST.
    pix_ce_d = en && run_q && (div_d == DIV_LAST);
  end

  always_ff @(posedge clock) begin
    if (res) begin
      run_q    <= 1'b0;
      div_q    <= '0;
      pix_ce_q <= 1'b0;
    end else begin
      run_q    <= run_d;
      div_q    <= div_d;
      pix_ce_q <= pix_ce_d;
    end
  end

  assign pix_ce = pix_ce_q;

endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: 640x480 VGA raster scanner with a show-ahead pixel source.
//   clock, res          : system clock, synchronous active-high reset
//   en                  : scan enable; low holds the scan idle at (0,0)
//   pix_ce              : one-clock pixel enable (from vga_pix_ce)
//   hcount, vcount      : position of the pixel being fetched
//   pix_req             : pop strobe; pix_valid/pix_data are sampled in the same clock
//   hsync, vsync, de, rgb : registered video outputs, one pixel behind hcount/vcount
//   frame_start         : pulse with the pix_ce at (0,0)
//   underflow           : sticky flag, set when a pop finds no valid pixel
module vga_scan_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int RGB_W   = vga_pkg::RGB_W
) (
  input  logic             clock,
  input  logic             res,
  input  logic             en,
  output logic             pix_ce,
  output logic [9:0]       hcount,
  output logic [9:0]       vcount,
  output logic             pix_req,
  input  logic             pix_valid,
  input  logic [RGB_W-1:0] pix_data,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [RGB_W-1:0] rgb,
  output logic             frame_start,
  output logic             underflow
);

  import vga_pkg::*;

  cnt_t             hcount_q, hcount_d;
  cnt_t             vcount_q, vcount_d;
  vid_ctl_t         ctl_q, ctl_d, ctl_pos;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             underflow_q, underflow_d;
  logic             pix_ce_w;

  vga_pix_ce #(.CLK_DIV(CLK_DIV)) u_pix_ce (
    .clock  (clock),
    .res    (res),
    .en     (en),
    .pix_ce (pix_ce_w)
  );

  assign ctl_pos = decode_pos(hcount_q, vcount_q);

  // Both strobes are the pix_ce flop qualified by decodes of the counter flops.
  // The en term kills a pop in the clock where en drops, so no partial
  // request leaks out of an aborted frame.
  assign pix_req     = pix_ce_w & en & ctl_pos.de;
  assign frame_start = pix_ce_w & en & (hcount_q == '0) & (vcount_q == '0);

  always_comb begin
    hcount_d    = hcount_q;
    vcount_d    = vcount_q;
    ctl_d       = ctl_q;
    rgb_d       = rgb_q;
    underflow_d = underflow_q | (pix_req & ~pix_valid);
    if (!en) begin
      hcount_d = '0;
      vcount_d = '0;
      ctl_d    = CTL_IDLE;
      rgb_d    = '0;
    end else if (pix_ce_w) begin
      // Video outputs describe the pixel being left. The counters advance to the next one.
      ctl_d = ctl_pos;
      rgb_d = (pix_req && pix_valid) ? pix_data : '0;
      if (hcount_q == cnt_t'(H_TOTAL - 1)) begin
        hcount_d = '0;
        vcount_d = (vcount_q == cnt_t'(V_TOTAL - 1)) ? '0 : vcount_q + cnt_t'(1);
      end else begin
        hcount_d = hcount_q + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (res) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      ctl_q       <= CTL_IDLE;
      rgb_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      ctl_q       <= ctl_d;
      rgb_q       <= rgb_d;
      underflow_q <= underflow_d;
    end
  end

  assign pix_ce    = pix_ce_w;
  assign hcount    = hcount_q;
  assign vcount    = vcount_q;
  assign hsync     = ctl_q.hsync_n;
  assign vsync     = ctl_q.vsync_n;
  assign de        = ctl_q.de;
  assign rgb       = rgb_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
module tb_vga_scan_ctrl;

  logic        clock = 1'b0;
  logic        res = 1'b1;
  logic        en = 1'b0;
  logic        pix_ce, pix_req, pix_valid, hsync, vsync, de, frame_start, underflow;
  logic [9:0]  hcount, vcount;
  logic [11:0] pix_data, rgb;

  vga_scan_ctrl #(.CLK_DIV(4), .RGB_W(12)) dut (
    .clock(clock), .res(res), .en(en), .pix_ce(pix_ce), .hcount(hcount), .vcount(vcount),
    .pix_req(pix_req), .pix_valid(pix_valid), .pix_data(pix_data), .hsync(hsync),
    .vsync(vsync), .de(de), .rgb(rgb), .frame_start(frame_start), .underflow(underflow)
  );

  always #5 clock = ~clock;

  // Show-ahead source: colour = hcount[3:0]*0x111. It can be starved once at (SH,SV).
  localparam int SH = 100;
  localparam int SV = 1;
  logic starve_arm = 1'b0;
  assign pix_data  = {3{hcount[3:0]}};
  assign pix_valid = !(starve_arm && hcount == 10'(SH) && vcount == 10'(SV));

  typedef struct { logic [11:0] rgb; logic de; logic hs; logic vs; } exp_t;
  exp_t sb[$];

  int ncmp = 0, nfail = 0;
  int mh = 0, mv = 0;          // model position of the next pix_ce
  logic um = 1'b0;             // model underflow
  int cyc = 0, last_ce = 0, hs_lo = 0;
  bit first = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample #1 after the edge. Pop the pixel pushed
  // on the previous pix_ce, then model this clock.
  task automatic tick();
    exp_t e;
    bit act, starve;
    @(posedge clock); #1;
    cyc++;
    if (hsync === 1'b0) hs_lo++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rgb", rgb, e.rgb);
      chk("de", de, e.de);
      chk("hsync", hsync, e.hs);
      chk("vsync", vsync, e.vs);
    end
    chk("underflow", underflow, um);
    if (pix_ce === 1'b1) begin
      if (!first) chk("ce_gap", cyc - last_ce, 4);
      first = 1'b0;
      last_ce = cyc;
      chk("hcount", hcount, mh);
      chk("vcount", vcount, mv);
      act = (mh < 640) && (mv < 480);
      starve = act && starve_arm && mh == SH && mv == SV;
      chk("pix_req", pix_req, act);
      chk("frame_start", frame_start, (mh == 0 && mv == 0));
      e.rgb = (act && !starve) ? 12'((mh % 16) * 'h111) : 12'h000;
      e.de  = act;
      e.hs  = !(mh >= 656 && mh <= 751);
      e.vs  = !(mv >= 490 && mv <= 491);
      sb.push_back(e);
      if (starve) um = 1'b1;
      if (mh == 799) begin
        mh = 0;
        mv = (mv == 524) ? 0 : mv + 1;
      end else mh++;
    end else begin
      chk("pix_req_idle", pix_req, 0);
      chk("frame_start_idle", frame_start, 0);
    end
  endtask

  task automatic wait_pix(input int h, input int v);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < 20000) begin
      tick();
      n++;
      hit = (pix_ce === 1'b1 && hcount == 10'(h) && vcount == 10'(v));
    end
    chk("reach_pos", hit, 1);
  endtask

  // Clocks from a start condition until the first pix_ce, which must be (0,0).
  task automatic expect_start(input string tag);
    int n = 0;
    do begin tick(); n++; end while (pix_ce !== 1'b1 && n < 12);
    chk(tag, n, 4);
    chk("first_frame_start", frame_start, 1);
  endtask

  task automatic chk_idle(input string tag, input logic uf);
    chk({tag, "_hcount"}, hcount, 0);
    chk({tag, "_vcount"}, vcount, 0);
    chk({tag, "_rgb"}, rgb, 0);
    chk({tag, "_de"}, de, 0);
    chk({tag, "_hsync"}, hsync, 1);
    chk({tag, "_vsync"}, vsync, 1);
    chk({tag, "_pix_ce"}, pix_ce, 0);
    chk({tag, "_underflow"}, underflow, uf);
  endtask

  initial begin
    // Reset state.
    repeat (3) tick();
    chk_idle("reset", 1'b0);

    // Enable. The first pix_ce comes 4 clocks later, at (0,0).
    res = 1'b0; en = 1'b1;
    expect_start("start_latency");

    // Line 0 with the source always valid.
    wait_pix(0, 1);
    // Line 1: count hsync-low clocks and starve the pop at (SH,SV).
    starve_arm = 1'b1;
    hs_lo = 0;
    repeat (3200) tick();
    chk("hsync_low_clocks", hs_lo, 384);
    chk("underflow_sticky", underflow, 1);
    starve_arm = 1'b0;

    // Drop en at (320,2). The frame aborts, and underflow holds.
    wait_pix(320, 2);
    en = 1'b0;
    sb.delete();
    mh = 0; mv = 0; first = 1'b1;
    tick();
    chk_idle("abort", 1'b1);
    repeat (9) tick();
    chk_idle("idle", 1'b1);
    en = 1'b1;
    expect_start("restart_latency");

    // Assert res mid-line at (500,3) with en held high.
    wait_pix(500, 3);
    res = 1'b1;
    sb.delete();
    mh = 0; mv = 0; first = 1'b1; um = 1'b0;
    tick();
    chk_idle("midres", 1'b0);
    tick();
    res = 1'b0;
    expect_start("res_restart_latency");
    repeat (3300) tick();
    chk("underflow_clean", underflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
